// File: rtl/uart_rx_ext_if.sv
// Serial-in / frame-out bundle for the extended UART receiver.
// master = receiver side, slave = line driver and frame consumer.
`timescale 1ns/1ps
interface uart_rx_ext_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_RX_Serial;
  logic                 o_RX_DV;
  logic [DATA_BITS-1:0] o_RX_Byte;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Busy;

  modport master (
    input  i_RX_Serial,
    output o_RX_DV,
    output o_RX_Byte,
    output o_Parity_Err,
    output o_Frame_Err,
    output o_Busy
  );

  modport slave (
    output i_RX_Serial,
    input  o_RX_DV,
    input  o_RX_Byte,
    input  o_Parity_Err,
    input  o_Frame_Err,
    input  o_Busy
  );
endinterface

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: sync + 3-sample vote, parity/framing
// errors, false-start and break rejection.
`timescale 1ns/1ps
module uart_rx_ext #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           i_Clk,
  input  logic           i_Rst_L,
  uart_rx_ext_if.master  rx
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int IW  = $clog2(DATA_BITS);
  localparam int MID = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] C_S1   = CW'(MID);
  localparam logic [CW-1:0] C_VOTE = CW'(MID + 1);
  localparam logic [3:0]    D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    S_LAST = 4'(STOP_BITS - 1);
  localparam logic          P_ODD  = (PARITY == 1);
  localparam logic          P_EN   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA,
    S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t state, state_n;

  logic                 sync1, rx_s;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic                 smp0, smp1;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err, frm_err;
  logic                 armed;
  logic                 vote, exp_par;
  logic                 at_vote, at_end;

  assign at_vote = (cnt == C_VOTE);
  assign at_end  = (cnt == C_LAST);
  assign vote    = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
  assign exp_par = (^shift) ^ P_ODD;
  assign rx.o_Busy = (state != S_IDLE);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx.i_RX_Serial;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (!rx_s && armed) state_n = S_START;
      S_START:
        if (at_vote && vote) state_n = S_IDLE;
        else if (at_end)     state_n = S_DATA;
      S_DATA:
        if (at_end && bit_idx == D_LAST)
          state_n = P_EN ? S_PARITY : S_STOP;
      S_PARITY:
        if (at_end) state_n = S_STOP;
      S_STOP:
        if (at_vote && bit_idx == S_LAST)
          state_n = S_DONE;
      S_DONE:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt             <= '0;
      bit_idx         <= '0;
      smp0            <= 1'b1;
      smp1            <= 1'b1;
      shift           <= '0;
      par_err         <= 1'b0;
      frm_err         <= 1'b0;
      armed           <= 1'b1;
      rx.o_RX_DV      <= 1'b0;
      rx.o_RX_Byte    <= '0;
      rx.o_Parity_Err <= 1'b0;
      rx.o_Frame_Err  <= 1'b0;
    end else begin
      rx.o_RX_DV <= 1'b0;

      if (state == S_IDLE || state_n == S_IDLE ||
          state_n == S_DONE || at_end)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (cnt == C_S0) smp0 <= rx_s;
      if (cnt == C_S1) smp1 <= rx_s;

      unique case (state)
        S_IDLE: begin
          bit_idx <= '0;
          if (rx_s) armed <= 1'b1;
          if (state_n == S_START) begin
            par_err <= 1'b0;
            frm_err <= 1'b0;
          end
        end
        S_DATA: begin
          if (at_vote) shift[bit_idx[IW-1:0]] <= vote;
          if (at_end)
            bit_idx <= (bit_idx == D_LAST) ? 4'd0 : bit_idx + 4'd1;
        end
        S_PARITY: begin
          if (at_vote && vote != exp_par) par_err <= 1'b1;
        end
        S_STOP: begin
          if (at_vote && !vote) frm_err <= 1'b1;
          if (at_end) bit_idx <= bit_idx + 4'd1;
          // Deliver mid last stop bit; a bad frame disarms until idle-high
          if (state_n == S_DONE) begin
            rx.o_RX_DV      <= 1'b1;
            rx.o_RX_Byte    <= shift;
            rx.o_Parity_Err <= P_EN & par_err;
            rx.o_Frame_Err  <= frm_err | ~vote;
            if (frm_err || !vote) armed <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: 8N1, 8E2 and 7O1 instances,
// queue scoreboard with a negedge monitor.
`timescale 1ns/1ps
module tb_uart_rx_ext;

  localparam int CPB    = 217;
  localparam int BIT_NS = CPB * 40;
  localparam int MIDC   = (CPB - 1) / 2;

  typedef struct {
    int         d;
    logic [8:0] b;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] ser = 3'b111;
  always #20 clk = ~clk;

  uart_rx_ext_if #(.DATA_BITS(8)) if_a ();
  uart_rx_ext_if #(.DATA_BITS(8)) if_b ();
  uart_rx_ext_if #(.DATA_BITS(7)) if_c ();

  assign if_a.i_RX_Serial = ser[0];
  assign if_b.i_RX_Serial = ser[1];
  assign if_c.i_RX_Serial = ser[2];

  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1)) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .rx(if_a.master));
  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(2)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .rx(if_b.master));
  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(7),
                .PARITY(1), .STOP_BITS(1)) dut_c (
    .i_Clk(clk), .i_Rst_L(rst_n), .rx(if_c.master));

  wire [2:0] dv   = {if_c.o_RX_DV, if_b.o_RX_DV, if_a.o_RX_DV};
  wire [2:0] busy = {if_c.o_Busy, if_b.o_Busy, if_a.o_Busy};
  wire [2:0] pe   = {if_c.o_Parity_Err, if_b.o_Parity_Err,
                     if_a.o_Parity_Err};
  wire [2:0] fe   = {if_c.o_Frame_Err, if_b.o_Frame_Err,
                     if_a.o_Frame_Err};
  logic [8:0] by [3];
  assign by[0] = {1'b0, if_a.o_RX_Byte};
  assign by[1] = {1'b0, if_b.o_RX_Byte};
  assign by[2] = {2'b0, if_c.o_RX_Byte};

  // START entry to DV: N*CPB + MID + 2, N = 9, 11, 9
  int lat [3] = '{9 * CPB + MIDC + 2,
                  11 * CPB + MIDC + 2,
                  9 * CPB + MIDC + 2};

  int checks = 0;
  int failures = 0;
  exp_t sbq [$];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic expect_rx(input int d, input logic [8:0] b,
                           input logic p, input logic f);
    exp_t e;
    e.d = d; e.b = b; e.pe = p; e.fe = f;
    sbq.push_back(e);
  endtask

  task automatic drive(input int d, input logic v);
    ser[d] = v;
    #(BIT_NS);
  endtask

  task automatic send_frame(input int d, input logic [8:0] data,
                            input int nb, input int np,
                            input logic pbit, input int nstop,
                            input logic [1:0] stops);
    drive(d, 1'b0);
    for (int i = 0; i < nb; i++) drive(d, data[i]);
    if (np != 0) drive(d, pbit);
    for (int i = 0; i < nstop; i++) drive(d, stops[i]);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sbq.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({"drain_", nm}, sbq.size(), 0);
    sbq.delete();
  endtask

  // Monitor
  int cyc = 0;
  int t0 [3] = '{0, 0, 0};
  logic [2:0] pdv = '0;
  logic [2:0] pbusy = '0;
  logic [8:0] lb [3];
  logic [2:0] lpe = '0;
  logic [2:0] lfe = '0;
  exp_t me;

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        lb[d] = '0; lpe[d] = 1'b0; lfe[d] = 1'b0;
        pdv[d] = 1'b0; pbusy[d] = 1'b0;
      end else begin
        if (busy[d] && !pbusy[d]) t0[d] = cyc;
        if (pdv[d])
          chk($sformatf("busy_after_dv%0d", d), int'(busy[d]), 0);
        if (dv[d]) begin
          chk($sformatf("dv_width%0d", d), int'(pdv[d]), 0);
          chk($sformatf("latency%0d", d), cyc - t0[d], lat[d]);
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_dv%0d: got byte 0x%0h, required no DV",
                     d, by[d]);
          end else begin
            me = sbq.pop_front();
            chk($sformatf("dv_src%0d", d), d, me.d);
            chk($sformatf("byte%0d", d), int'(by[d]), int'(me.b));
            chk($sformatf("perr%0d", d), int'(pe[d]), int'(me.pe));
            chk($sformatf("ferr%0d", d), int'(fe[d]), int'(me.fe));
          end
          lb[d] = by[d]; lpe[d] = pe[d]; lfe[d] = fe[d];
        end else begin
          chk($sformatf("hold%0d", d),
              int'({by[d], pe[d], fe[d]}),
              int'({lb[d], lpe[d], lfe[d]}));
        end
        pdv[d] = dv[d];
        pbusy[d] = busy[d];
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ser = 3'b111;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_byte", int'(by[0]), 0);
    chk("rst_dv", int'(dv), 0);
    chk("rst_perr", int'(pe), 0);
    chk("rst_ferr", int'(fe), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk); #5 rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 8N1 basic
    expect_rx(0, 9'h37, 1'b0, 1'b0);
    send_frame(0, 9'h37, 8, 0, 1'b0, 1, 2'b11);
    drain("8n1_37");
    repeat (50) @(negedge clk);

    // False start on idle line
    @(negedge clk);
    ser[0] = 1'b0;
    #400;
    chk("glitch_busy_hi", int'(busy[0]), 1);
    #1600;
    ser[0] = 1'b1;
    #(BIT_NS - 2000);
    chk("glitch_back_idle", int'(busy[0]), 0);
    repeat (50) @(negedge clk);

    // 0xFF, one-clock low aligned to the MID sample of data bit 3
    expect_rx(0, 9'h0FF, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      if (j == 3) begin
        ser[0] = 1'b1; #4360;
        ser[0] = 1'b0; #40;
        ser[0] = 1'b1; #(BIT_NS - 4400);
      end else begin
        drive(0, 1'b1);
      end
    end
    drive(0, 1'b1);
    drain("vote_ff");
    repeat (50) @(negedge clk);

    // Reset during data bit 3 of 0xC3
    @(negedge clk);
    fork
      send_frame(0, 9'h0C3, 8, 0, 1'b0, 1, 2'b11);
      begin
        #(4 * BIT_NS + 4000);
        rst_n = 1'b0;
        #1;
        chk("midrst_byte", int'(by[0]), 0);
        chk("midrst_dv", int'(dv[0]), 0);
        chk("midrst_perr", int'(pe[0]), 0);
        chk("midrst_ferr", int'(fe[0]), 0);
        chk("midrst_busy", int'(busy[0]), 0);
      end
    join
    @(negedge clk); #5 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    expect_rx(0, 9'h03C, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 2'b11);
    drain("after_rst_3c");
    repeat (50) @(negedge clk);

    // Even parity, 2 stop bits
    @(negedge clk);
    expect_rx(1, 9'h0A5, 1'b0, 1'b0);
    send_frame(1, 9'h0A5, 8, 1, 1'b0, 2, 2'b11);
    drain("even_ok");
    expect_rx(1, 9'h0A5, 1'b1, 1'b0);
    send_frame(1, 9'h0A5, 8, 1, 1'b1, 2, 2'b11);
    drain("even_bad");

    // Second stop bit low, then break for 3 frames
    expect_rx(1, 9'h05A, 1'b0, 1'b1);
    send_frame(1, 9'h05A, 8, 1, 1'b0, 2, 2'b01);
    drain("frame_err");
    #(18 * BIT_NS);
    chk("break_idle", int'(busy[1]), 0);
    #(18 * BIT_NS);
    ser[1] = 1'b1;
    #(2 * BIT_NS);
    @(negedge clk);
    expect_rx(1, 9'h011, 1'b0, 1'b0);
    send_frame(1, 9'h011, 8, 1, 1'b0, 2, 2'b11);
    drain("after_break");
    repeat (50) @(negedge clk);

    // 7O1 back-to-back
    @(negedge clk);
    expect_rx(2, 9'h07F, 1'b0, 1'b0);
    expect_rx(2, 9'h000, 1'b0, 1'b0);
    expect_rx(2, 9'h02A, 1'b0, 1'b0);
    send_frame(2, 9'h07F, 7, 1, 1'b0, 1, 2'b11);
    send_frame(2, 9'h000, 7, 1, 1'b1, 1, 2'b11);
    send_frame(2, 9'h02A, 7, 1, 1'b0, 1, 2'b11);
    drain("b2b_7o1");

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
